// File: rtl/red_pitaya_trigger_sequencer.sv
// ---------------------------------------------------------------------------
// red_pitaya_trigger_sequencer
//
// Runs the trigger block through a burst of N armed acquisitions without
// software polling. For each shot it pulses rearm_o and waits for trig_i. It
// then counts out a holdoff before re-arming. A wait that exceeds the
// programmed timeout ends the burst early. The module has its own register
// window on the PS bus.
//
// Ports
//   clk_i   in   1   clock
//   rst_i   in   1   reset, asynchronous, active-high
//   trig_i  in   1   1-cycle trigger pulse from the trigger block
//   rearm_o out  1   1-cycle rearm pulse to the trigger block
//   busy_o  out  1   high while a burst is in progress
//   done_o  out  1   1-cycle pulse when a burst completes normally
//   addr    in   16  bus address
//   wen     in   1   bus write strobe
//   ren     in   1   bus read strobe
//   ack     out  1   bus acknowledge, one cycle after any strobe
//   rdata   out  32  registered bus read data (0 for unmapped addresses)
//   wdata   in   32  bus write data
//
// Register map
//   0x100 W: bit0 start, bit1 abort (self-clearing)
//         R: {28'b0, timeout_flag, done_flag, busy, 1'b0}
//   0x104 RW n_trig (0 behaves as 1)
//   0x108 RW holdoff cycles
//   0x10C RW timeout cycles (0 disables the timeout)
//   0x110 R  shot_count
//   0x114 R  last_interval (cycles between the last two accepted triggers)
//   0x118 R  missed (triggers seen outside WAIT_TRIG, saturating)
// ---------------------------------------------------------------------------
module red_pitaya_trigger_sequencer #(
    parameter int TMR_W   = 32,
    parameter int NTRIG_W = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        trig_i,
    output logic        rearm_o,
    output logic        busy_o,
    output logic        done_o,
    input  logic [15:0] addr,
    input  logic        wen,
    input  logic        ren,
    output logic        ack,
    output logic [31:0] rdata,
    input  logic [31:0] wdata
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARM       = 2'd1,
        WAIT_TRIG = 2'd2,
        HOLDOFF   = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [NTRIG_W-1:0] n_trig;
    logic [TMR_W-1:0]   holdoff;
    logic [TMR_W-1:0]   timeout;
    logic [NTRIG_W-1:0] shot_count;
    logic [TMR_W-1:0]   last_interval;
    logic [TMR_W-1:0]   last_stamp;
    logic [TMR_W-1:0]   missed;
    logic [TMR_W-1:0]   timer;
    logic [TMR_W-1:0]   wait_cnt;
    logic [TMR_W-1:0]   hold_cnt;
    logic               done_flag;
    logic               timeout_flag;

    logic               ctrl_wr;
    logic               start_req;
    logic               abort_req;
    logic               busy;
    logic [NTRIG_W-1:0] n_eff;
    logic [NTRIG_W-1:0] shot_inc;
    logic [TMR_W:0]     wait_inc;
    logic               shot_acc;
    logic               burst_end;
    logic               tmo_hit;
    logic [31:0]        rd_mux;

    // Saturating increment for the missed-trigger counter.
    function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] v);
        return (&v) ? v : v + TMR_W'(1);
    endfunction

    assign ctrl_wr   = wen && (addr == 16'h0100);
    assign start_req = ctrl_wr && wdata[0];
    assign abort_req = ctrl_wr && wdata[1];
    assign busy      = (state != IDLE);
    assign n_eff     = (n_trig == '0) ? NTRIG_W'(1) : n_trig;
    assign shot_inc  = shot_count + NTRIG_W'(1);
    // One bit wider so the compare cannot wrap when timeout is all-ones.
    assign wait_inc  = {1'b0, wait_cnt} + {{TMR_W{1'b0}}, 1'b1};

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. Abort overrides everything, including a trigger or a
    // start in the same cycle. A trigger on the timeout cycle still counts.
    always_comb begin
        state_nxt = state;
        shot_acc  = 1'b0;
        burst_end = 1'b0;
        tmo_hit   = 1'b0;
        if (abort_req) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_req) state_nxt = ARM;
                end
                ARM: begin
                    state_nxt = WAIT_TRIG;
                end
                WAIT_TRIG: begin
                    if (trig_i) begin
                        shot_acc = 1'b1;
                        if (shot_inc >= n_eff) begin
                            burst_end = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = HOLDOFF;
                        end
                    end else if ((timeout != '0) && (wait_inc >= {1'b0, timeout})) begin
                        tmo_hit   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                HOLDOFF: begin
                    if (hold_cnt == '0) state_nxt = ARM;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Sequencer datapath and registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rearm_o       <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            timer         <= '0;
            wait_cnt      <= '0;
            hold_cnt      <= '0;
            shot_count    <= '0;
            last_interval <= '0;
            last_stamp    <= '0;
            missed        <= '0;
            done_flag     <= 1'b0;
            timeout_flag  <= 1'b0;
        end else begin
            // Outputs come from the next state so they line up with the state.
            rearm_o <= (state_nxt == ARM);
            busy_o  <= (state_nxt != IDLE);
            done_o  <= burst_end;
            timer   <= timer + TMR_W'(1);

            if (state == ARM) begin
                wait_cnt <= '0;
            end else if (state == WAIT_TRIG) begin
                wait_cnt <= wait_cnt + TMR_W'(1);
            end

            if ((state == IDLE) && (state_nxt == ARM)) begin
                shot_count   <= '0;
                done_flag    <= 1'b0;
                timeout_flag <= 1'b0;
            end

            if (shot_acc) begin
                shot_count <= shot_inc;
                // The first shot of a burst has no previous trigger to measure from.
                if (shot_count != '0) begin
                    last_interval <= timer - last_stamp;
                end
                last_stamp <= timer;
            end

            if (burst_end) done_flag    <= 1'b1;
            if (tmo_hit)   timeout_flag <= 1'b1;

            // The holdoff value is sampled only when a shot is accepted.
            if ((state == WAIT_TRIG) && (state_nxt == HOLDOFF)) begin
                hold_cnt <= holdoff;
            end else if ((state == HOLDOFF) && (hold_cnt != '0)) begin
                hold_cnt <= hold_cnt - TMR_W'(1);
            end

            if (trig_i && (state != WAIT_TRIG)) begin
                missed <= sat_inc(missed);
            end
        end
    end

    // Bus read mux
    always_comb begin
        rd_mux = 32'd0;
        case (addr)
            16'h0100: rd_mux = {28'd0, timeout_flag, done_flag, busy, 1'b0};
            16'h0104: rd_mux = 32'(n_trig);
            16'h0108: rd_mux = 32'(holdoff);
            16'h010C: rd_mux = 32'(timeout);
            16'h0110: rd_mux = 32'(shot_count);
            16'h0114: rd_mux = 32'(last_interval);
            16'h0118: rd_mux = 32'(missed);
            default:  rd_mux = 32'd0;
        endcase
    end

    // Bus registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack     <= 1'b0;
            rdata   <= 32'd0;
            n_trig  <= '0;
            holdoff <= '0;
            timeout <= '0;
        end else begin
            ack <= wen | ren;
            if (ren) rdata <= rd_mux;
            if (wen) begin
                case (addr)
                    16'h0104: n_trig  <= wdata[NTRIG_W-1:0];
                    16'h0108: holdoff <= TMR_W'(wdata);
                    16'h010C: timeout <= TMR_W'(wdata);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_red_pitaya_trigger_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for red_pitaya_trigger_sequencer.
// Each burst is planned up front from the sequencing rules using plain cycle
// arithmetic. The plan covers rearm/done times, trigger schedule, busy window
// and final register values. The driver replays the plan open-loop. A
// negedge monitor pops the expected-event queues whenever the DUT raises
// rearm_o, done_o or ack.
// ---------------------------------------------------------------------------
module tb_red_pitaya_trigger_sequencer;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        trig_i;
    logic        rearm_o;
    logic        busy_o;
    logic        done_o;
    logic [15:0] addr;
    logic        wen;
    logic        ren;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] wdata;

    red_pitaya_trigger_sequencer #(.TMR_W(32), .NTRIG_W(16)) dut (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .trig_i (trig_i),
        .rearm_o(rearm_o),
        .busy_o (busy_o),
        .done_o (done_o),
        .addr   (addr),
        .wen    (wen),
        .ren    (ren),
        .ack    (ack),
        .rdata  (rdata),
        .wdata  (wdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          rd;
        logic [15:0] a;
        logic [31:0] data;
        int          when;
    } ack_t;

    ack_t ackq[$];
    int   rearm_q[$];
    int   done_q[$];
    ack_t mon_a;
    int   busy_lo = 1;
    int   busy_hi = 0;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state
    int m_ntrig, m_hold, m_tmo, m_shots, m_interval, m_missed;
    bit m_done, m_tflag;
    int dly[8];

    function automatic void chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (!rst_i) begin
            if (rearm_o) begin
                chk("rearm_expected", rearm_q.size() > 0, 1);
                if (rearm_q.size() > 0) chk("rearm_cycle", cyc, rearm_q.pop_front());
            end
            if (done_o) begin
                chk("done_expected", done_q.size() > 0, 1);
                if (done_q.size() > 0) chk("done_cycle", cyc, done_q.pop_front());
            end
            chk("busy", busy_o, (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
            if (ack) begin
                chk("ack_expected", ackq.size() > 0, 1);
                if (ackq.size() > 0) begin
                    mon_a = ackq.pop_front();
                    chk("ack_cycle", cyc, mon_a.when);
                    if (mon_a.rd) chk($sformatf("rdata_%h", mon_a.a), rdata, mon_a.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        wen = 1'b1; addr = a; wdata = d;
        ackq.push_back('{1'b0, a, 32'd0, cyc + 1});
        step();
        wen = 1'b0; addr = 16'd0; wdata = 32'd0;
    endtask

    task automatic bus_read(input logic [15:0] a, input logic [31:0] exp);
        ren = 1'b1; addr = a;
        ackq.push_back('{1'b1, a, exp, cyc + 1});
        step();
        ren = 1'b0; addr = 16'd0;
    endtask

    task automatic cfg(input int n, input int h, input int t);
        bus_write(16'h0104, n);
        bus_write(16'h0108, h);
        bus_write(16'h010C, t);
        m_ntrig = n; m_hold = h; m_tmo = t;
        bus_read(16'h0104, n);
        bus_read(16'h010C, t);
    endtask

    task automatic check_regs();
        bus_read(16'h0100, {28'd0, m_tflag, m_done, 2'b00});
        bus_read(16'h0110, m_shots);
        bus_read(16'h0114, m_interval);
        bus_read(16'h0118, m_missed);
        bus_read(16'h0108, m_hold);
    endtask

    // Plan one burst from the rules, then replay it.
    // late_trig: still pulse trig_i after a timeout expired.
    // abort_off: >=0 writes abort that many cycles into the first holdoff.
    // extra_cnt: stray triggers issued inside every holdoff window.
    task automatic run_burst(input bit late_trig, input int abort_off, input int extra_cnt);
        int ts, r, tp, n_eff, end_p, last_p, abort_p, last_acc;
        int tq[$];
        ts = cyc; abort_p = -1; last_acc = 0; end_p = ts + 1;
        n_eff = (m_ntrig == 0) ? 1 : m_ntrig;
        m_shots = 0; m_done = 0; m_tflag = 0;
        r = ts + 1;
        for (int k = 0; k < n_eff; k++) begin
            rearm_q.push_back(r);
            if (m_tmo != 0 && dly[k] > m_tmo) begin
                end_p = r + m_tmo + 1;
                m_tflag = 1;
                if (late_trig) begin
                    tq.push_back(r + dly[k]);
                    m_missed++;
                end
                break;
            end
            tp = r + dly[k];
            tq.push_back(tp);
            m_shots++;
            if (m_shots > 1) m_interval = tp - last_acc;
            last_acc = tp;
            if (m_shots == n_eff) begin
                done_q.push_back(tp + 1);
                m_done = 1;
                end_p = tp + 1;
                break;
            end
            if (abort_off >= 0) begin
                abort_p = tp + 1 + abort_off;
                end_p = abort_p + 1;
                break;
            end
            for (int e = 0; e < extra_cnt; e++) begin
                tq.push_back(tp + 1 + e);
                m_missed++;
            end
            r = tp + m_hold + 2;
        end
        busy_lo = ts + 1;
        busy_hi = end_p - 1;
        last_p = end_p + 2;
        if (tq.size() > 0 && tq[tq.size()-1] > last_p) last_p = tq[tq.size()-1];
        for (int p = ts; p <= last_p; p++) begin
            wen = 1'b0; addr = 16'd0; wdata = 32'd0; trig_i = 1'b0;
            if (p == ts) begin
                wen = 1'b1; addr = 16'h0100; wdata = 32'd1;
                ackq.push_back('{1'b0, 16'h0100, 32'd0, p + 1});
            end
            if (p == abort_p) begin
                wen = 1'b1; addr = 16'h0100; wdata = 32'd2;
                ackq.push_back('{1'b0, 16'h0100, 32'd0, p + 1});
            end
            if (tq.size() > 0 && tq[0] == p) begin
                trig_i = 1'b1;
                void'(tq.pop_front());
            end
            step();
        end
        wen = 1'b0; addr = 16'd0; wdata = 32'd0; trig_i = 1'b0;
        chk("rearm_missing", rearm_q.size(), 0);
        chk("done_missing", done_q.size(), 0);
    endtask

    task automatic model_reset();
        m_ntrig = 0; m_hold = 0; m_tmo = 0; m_shots = 0;
        m_interval = 0; m_missed = 0; m_done = 0; m_tflag = 0;
    endtask

    task automatic check_all_zero();
        bus_read(16'h0100, 0);
        bus_read(16'h0104, 0);
        bus_read(16'h0108, 0);
        bus_read(16'h010C, 0);
        bus_read(16'h0110, 0);
        bus_read(16'h0114, 0);
        bus_read(16'h0118, 0);
        bus_read(16'h011C, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ts, n, h, t, ex;
        rst_i = 1'b1; trig_i = 1'b0; wen = 1'b0; ren = 1'b0;
        addr = 16'd0; wdata = 32'd0;
        model_reset();
        #2;
        chk("rst_rearm", rearm_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_ack", ack, 0);
        chk("rst_rdata", rdata, 0);
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        check_all_zero();

        // Three-shot burst: rearms 17 cycles apart.
        cfg(3, 10, 0);
        dly[0] = 5; dly[1] = 5; dly[2] = 5;
        run_burst(0, -1, 0);
        check_regs();

        // Stray triggers: three in IDLE, two inside a holdoff.
        for (int i = 0; i < 3; i++) begin
            trig_i = 1'b1; step(); trig_i = 1'b0; step();
            m_missed++;
        end
        cfg(2, 8, 0);
        dly[0] = 4; dly[1] = 4;
        run_burst(0, -1, 2);
        check_regs();

        // Timeout with no trigger.
        cfg(1, 0, 100);
        dly[0] = 200;
        run_burst(0, -1, 0);
        check_regs();

        // Trigger on the timeout cycle is accepted.
        cfg(2, 3, 6);
        dly[0] = 6; dly[1] = 6;
        run_burst(0, -1, 0);
        check_regs();

        // Abort inside holdoff, then a fresh burst.
        cfg(3, 20, 0);
        dly[0] = 3;
        run_burst(0, 5, 0);
        check_regs();
        dly[0] = 2; dly[1] = 3; dly[2] = 4;
        run_burst(0, -1, 0);
        check_regs();

        // Randomized bursts.
        for (int b = 0; b < 12; b++) begin
            n = $urandom_range(0, 4);
            h = $urandom_range(0, 6);
            t = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 8) : 0;
            ex = $urandom_range(0, (h + 1 < 2) ? h + 1 : 2);
            for (int k = 0; k < 8; k++) dly[k] = $urandom_range(1, 8);
            cfg(n, h, t);
            run_burst($urandom_range(0, 1) == 1, -1, ex);
            check_regs();
        end

        // Asynchronous reset while waiting for a trigger.
        cfg(2, 0, 0);
        ts = cyc;
        rearm_q.push_back(ts + 1);
        busy_lo = ts + 1; busy_hi = ts + 1000;
        bus_write(16'h0100, 32'd1);
        step(); step();
        busy_hi = cyc - 1;
        rst_i = 1'b1;
        #1;
        chk("arst_rearm", rearm_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_done", done_o, 0);
        chk("arst_ack", ack, 0);
        chk("arst_rdata", rdata, 0);
        @(posedge clk); @(posedge clk);
        #1 rst_i = 1'b0;
        chk("arst_rearm_q", rearm_q.size(), 0);
        model_reset();
        check_all_zero();
        dly[0] = 4;
        run_burst(0, -1, 0);
        check_regs();

        step(); step();
        chk("ack_missing", ackq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
